// File: rtl/spi_master_tx_module.sv
// SPI mode-0 master transmitter: valid/ready byte input, MSB-first serialisation, cs held across a frame.
// Build option SPI_TX_BYTE_GAP_EN: every byte closes its own frame (cs pulses high between bytes).
module spi_master_tx_module #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, HOLD, WAIT, GAP} state_t;

  state_t     state, state_n;
  logic [7:0] hcnt, hcnt_n;
  logic [2:0] bcnt, bcnt_n;
  logic [6:0] shreg, shreg_n;
  logic       last, last_n;
  logic       sck_n, mosi_n, done_n;
  logic       accept, hwrap, req_last;

  assign accept = tx_valid && tx_ready;
  assign hwrap  = (hcnt == HMAX);

`ifdef SPI_TX_BYTE_GAP_EN
  // tx_last is deliberately overridden: each byte is its own frame
  assign req_last = tx_last | 1'b1;
`else
  assign req_last = tx_last;
`endif

  // State and registered outputs; outputs follow the next state so they line up with it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      hcnt     <= 8'd0;
      bcnt     <= 3'd0;
      shreg    <= 7'd0;
      last     <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      bcnt     <= bcnt_n;
      shreg    <= shreg_n;
      last     <= last_n;
      sck      <= sck_n;
      mosi     <= mosi_n;
      cs       <= (state_n == IDLE) || (state_n == GAP);
      tx_ready <= (state_n == IDLE) || (state_n == WAIT);
      busy     <= (state_n != IDLE);
      done     <= done_n;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    bcnt_n  = bcnt;
    shreg_n = shreg;
    last_n  = last;
    sck_n   = sck;
    mosi_n  = mosi;
    done_n  = 1'b0;

    case (state)
      IDLE, WAIT: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = tx_data[6:0];
          last_n  = req_last;
          mosi_n  = tx_data[7];
          sck_n   = 1'b0;
          hcnt_n  = 8'd0;
          bcnt_n  = 3'd0;
        end
      end
      SHIFT: begin
        if (hwrap) begin
          hcnt_n = 8'd0;
          if (!sck) begin
            sck_n = 1'b1;
          end else begin
            // falling edge: advance to the next bit, or finish the byte after bit 0
            sck_n   = 1'b0;
            shreg_n = {shreg[5:0], 1'b0};
            bcnt_n  = bcnt + 3'd1;
            if (bcnt == 3'd7) begin
              state_n = HOLD;
            end else begin
              mosi_n = shreg[6];
            end
          end
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      HOLD: begin
        if (hwrap) begin
          hcnt_n = 8'd0;
          if (last) begin
            state_n = GAP;
            mosi_n  = 1'b0;
          end else begin
            state_n = WAIT;
          end
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      GAP: begin
        if (hwrap) begin
          hcnt_n  = 8'd0;
          state_n = IDLE;
        end else begin
          hcnt_n = hcnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // done lands on the final cycle of HOLD
    done_n = (state_n == HOLD) && (hcnt_n == HMAX);
  end

endmodule
